// File: rtl/hazard_flow_ctrl.sv
// hazard_flow_ctrl: pipeline flow controller for the 5-stage ARM core.
// Generates the ready/flush controls consumed by the stage registers:
//   - global freeze (pipeReady=0) during fixed-latency data-memory accesses
//   - IF/ID freeze plus ID/EXE bubble on RAW hazards
//   - IF/ID and ID/EXE flush on taken branches (branch wins over a hazard)
//
// Optional build macro: HAZARD_FORWARD_EN
//   defined   : forwarding exists, only load-use hazards stall (MEM dest ignored)
//   undefined : no forwarding, any pending EXE/MEM write-back to a source stalls
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   idSrc1/idSrc2                 ID-stage source indices
//   idUsesSrc1/idTwoSrc           ID instruction reads idSrc1 / idSrc2
//   exeWbEn/exeMemRead/exeDest    EXE-stage write-back, load flag, destination
//   memWbEn/memDest               MEM-stage write-back and destination
//   memReq                        MEM-stage instruction performs a load or store
//   branchTaken                   EXE-stage branch taken
//   pipeReady                     0 freezes the whole pipe
//   pcFreeze/ifIdFreeze           hold PC / IF/ID register
//   ifIdFlush/idExFlush           clear IF/ID / bubble into ID/EXE
//   memBusy/memDone               access in progress / completes this cycle
//   stallCount/flushCount         saturating hazard-stall / branch-flush counters
module hazard_flow_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       idSrc1,
    input  logic [3:0]       idSrc2,
    input  logic             idTwoSrc,
    input  logic             idUsesSrc1,
    input  logic             exeWbEn,
    input  logic             exeMemRead,
    input  logic [3:0]       exeDest,
    input  logic             memWbEn,
    input  logic [3:0]       memDest,
    input  logic             memReq,
    input  logic             branchTaken,
    output logic             pipeReady,
    output logic             pcFreeze,
    output logic             ifIdFreeze,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             memBusy,
    output logic             memDone,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned  CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [3:0]   PC_IDX   = 4'hF;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("hazard_flow_ctrl: WAIT_CYCLES must be 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          m1, m2, hazard;
    logic          stall_c, flush_c;

    // Source match against in-flight destinations
`ifdef HAZARD_FORWARD_EN
    assign m1 = exeMemRead & exeWbEn & (exeDest == idSrc1);
    assign m2 = exeMemRead & exeWbEn & (exeDest == idSrc2);
    logic unused_mem;
    assign unused_mem = ^{memWbEn, memDest};
`else
    assign m1 = (exeWbEn & (exeDest == idSrc1)) | (memWbEn & (memDest == idSrc1));
    assign m2 = (exeWbEn & (exeDest == idSrc2)) | (memWbEn & (memDest == idSrc2));
    logic unused_exe;
    assign unused_exe = exeMemRead;
`endif

    // PC (r15) is never a register-file hazard
    assign hazard = (idUsesSrc1 & m1 & (idSrc1 != PC_IDX))
                  | (idTwoSrc   & m2 & (idSrc2 != PC_IDX));

    // Memory-access FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and memory freeze outputs
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pipeReady = 1'b1;
        memBusy   = 1'b0;
        memDone   = 1'b0;
        case (state)
            IDLE: begin
                if (memReq) begin
                    pipeReady = 1'b0;
                    memBusy   = 1'b1;
                    cnt_n     = CNT_LOAD;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                pipeReady = 1'b0;
                memBusy   = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                // memReq here is the request just served; do not restart
                memDone = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Stage controls; the global freeze overrides everything, branch beats hazard
    always_comb begin
        flush_c    = branchTaken & pipeReady;
        stall_c    = hazard & ~branchTaken & pipeReady;
        pcFreeze   = stall_c;
        ifIdFreeze = stall_c;
        ifIdFlush  = flush_c;
        idExFlush  = stall_c | flush_c;
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall_c && (stallCount != {CNT_W{1'b1}})) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (flush_c && (flushCount != {CNT_W{1'b1}})) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_flow_ctrl.sv
// Self-checking bench for hazard_flow_ctrl (WAIT_CYCLES=4, CNT_W=16).
// Expected control vectors and counter values are queued as each cycle is
// driven and popped/compared at the following negative clock edge.
`timescale 1ns/1ps
module tb_hazard_flow_ctrl;

    localparam int unsigned CNT_W = 16;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pipeReady, pcFreeze, ifIdFreeze, ifIdFlush, idExFlush, memBusy, memDone}
    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_FRZ    = 7'b0000010;
    localparam logic [6:0] C_DONE   = 7'b1000001;
    localparam logic [6:0] C_STALL  = 7'b1110100;
    localparam logic [6:0] C_FLUSH  = 7'b1001100;
    localparam logic [6:0] C_DFLUSH = 7'b1001101;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       idSrc1, idSrc2, exeDest, memDest;
    logic             idTwoSrc, idUsesSrc1, exeWbEn, exeMemRead;
    logic             memWbEn, memReq, branchTaken;
    logic             pipeReady, pcFreeze, ifIdFreeze, ifIdFlush, idExFlush;
    logic             memBusy, memDone;
    logic [CNT_W-1:0] stallCount, flushCount;
    logic [6:0]       obs;

    always #5 clk = ~clk;

    hazard_flow_ctrl #(.WAIT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc), .idUsesSrc1(idUsesSrc1),
        .exeWbEn(exeWbEn), .exeMemRead(exeMemRead), .exeDest(exeDest),
        .memWbEn(memWbEn), .memDest(memDest), .memReq(memReq), .branchTaken(branchTaken),
        .pipeReady(pipeReady), .pcFreeze(pcFreeze), .ifIdFreeze(ifIdFreeze),
        .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .memBusy(memBusy), .memDone(memDone),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    assign obs = {pipeReady, pcFreeze, ifIdFreeze, ifIdFlush, idExFlush, memBusy, memDone};

    typedef struct {
        string            name;
        logic [6:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] m_sc, m_fc;
    int               checks   = 0;
    int               failures = 0;

    task automatic clear_inputs();
        idSrc1 = 4'd0; idSrc2 = 4'd0; idTwoSrc = 1'b0; idUsesSrc1 = 1'b0;
        exeWbEn = 1'b0; exeMemRead = 1'b0; exeDest = 4'd0;
        memWbEn = 1'b0; memDest = 4'd0; memReq = 1'b0; branchTaken = 1'b0;
    endtask

    // Queue this cycle's expectation, then advance the counter model
    task automatic push_exp(input string name, input logic [6:0] ctl);
        exp_t e;
        e.name = name; e.ctl = ctl; e.sc = m_sc; e.fc = m_fc;
        exp_q.push_back(e);
        if (ctl[5] && m_sc != {CNT_W{1'b1}}) m_sc = m_sc + CNT_W'(1);
        if (ctl[3] && m_fc != {CNT_W{1'b1}}) m_fc = m_fc + CNT_W'(1);
    endtask

    task automatic test_reset();
        exp_t e;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_sc = '0;
        m_fc = '0;
        push_exp("reset", C_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
        checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
        checks++; if (flushCount !== e.fc) begin failures++; $display("FAIL %s flushCount got=%0h want=%0h", e.name, flushCount, e.fc); end
        @(posedge clk); #1;
    endtask

    task automatic test_mem_freeze();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            memReq = (i <= 5);
            push_exp($sformatf("mem_freeze%0d", i), (i < 5) ? C_FRZ : (i == 5) ? C_DONE : C_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_raw_stall();
        exp_t e;
        logic [6:0] want;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            want = C_IDLE;
            case (i)
                0: begin idSrc1 = 4'd3; idUsesSrc1 = 1'b1; memWbEn = 1'b1; memDest = 4'd3;
                         want = FWD ? C_IDLE : C_STALL; end
                1: begin idSrc1 = 4'd3; memWbEn = 1'b1; memDest = 4'd3; end
                2: begin idSrc1 = 4'd15; idUsesSrc1 = 1'b1; memWbEn = 1'b1; memDest = 4'd15;
                         exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd15; end
                3: begin idSrc1 = 4'd7; idUsesSrc1 = 1'b1; exeWbEn = 1'b1; exeMemRead = 1'b1;
                         exeDest = 4'd7; want = C_STALL; end
                default: ;
            endcase
            push_exp($sformatf("raw_stall%0d", i), want);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [6:0] want;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            want = C_IDLE;
            if (i < 4) begin
                exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd5; idSrc2 = 4'd5; idTwoSrc = 1'b1;
            end
            case (i)
                0: want = C_STALL;
                1: begin exeMemRead = 1'b0; want = FWD ? C_IDLE : C_STALL; end
                2: idTwoSrc = 1'b0;
                3: exeWbEn = 1'b0;
                default: ;
            endcase
            push_exp($sformatf("load_use%0d", i), want);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_priority();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            if (i == 0) begin
                exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd2; idSrc1 = 4'd2; idUsesSrc1 = 1'b1;
            end
            branchTaken = (i == 0) || (i == 2);
            push_exp($sformatf("branch_prio%0d", i), branchTaken ? C_FLUSH : C_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            checks++; if (flushCount !== e.fc) begin failures++; $display("FAIL %s flushCount got=%0h want=%0h", e.name, flushCount, e.fc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_freeze();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            memReq = (i == 0);
            if (i >= 1 && i <= 4) begin
                branchTaken = 1'b1;
                exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd4; idSrc1 = 4'd4; idUsesSrc1 = 1'b1;
            end
            if (i == 5) branchTaken = 1'b1;
            push_exp($sformatf("branch_freeze%0d", i), (i <= 4) ? C_FRZ : (i == 5) ? C_DFLUSH : C_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            checks++; if (flushCount !== e.fc) begin failures++; $display("FAIL %s flushCount got=%0h want=%0h", e.name, flushCount, e.fc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   total;
        clear_inputs();
        exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd9; idSrc1 = 4'd9; idUsesSrc1 = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        total = int'(m_sc) + 65540;
        m_sc = (total > 65535) ? {CNT_W{1'b1}} : CNT_W'(total);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) clear_inputs();
            push_exp($sformatf("saturate%0d", i), (i == 0) ? C_STALL : C_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [6:0] want;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            want = C_IDLE;
            case (i)
                0: begin memReq = 1'b1; want = C_FRZ; end
                1: want = C_FRZ;
                2: begin rst = 1'b1; want = C_FRZ; end
                3: begin rst = 1'b0; m_sc = '0; m_fc = '0; end
                4: begin exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd6;
                         idSrc2 = 4'd6; idTwoSrc = 1'b1; want = C_STALL; end
                default: ;
            endcase
            push_exp($sformatf("reset_mid%0d", i), want);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e.ctl) begin failures++; $display("FAIL %s ctl got=%b want=%b", e.name, obs, e.ctl); end
            checks++; if (stallCount !== e.sc) begin failures++; $display("FAIL %s stallCount got=%0h want=%0h", e.name, stallCount, e.sc); end
            checks++; if (flushCount !== e.fc) begin failures++; $display("FAIL %s flushCount got=%0h want=%0h", e.name, flushCount, e.fc); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        m_sc = '0;
        m_fc = '0;
        clear_inputs();
        test_reset();
        test_mem_freeze();
        test_raw_stall();
        test_load_use();
        test_branch_priority();
        test_branch_freeze();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_flow_ctrl.md
Name: hazard_flow_ctrl

Overview:
- Pipeline flow controller for the 5-stage ARM core; generates the `ready`/`flush` controls consumed by the stage registers.
- Drives:
  - global freeze during fixed-latency data-memory accesses;
  - IF/ID freeze plus ID/EXE bubble on RAW hazards;
  - IF/ID and ID/EXE flush on taken branches.
- Sits beside the pipeline; reads the ID-stage sources and the EXE/MEM destinations.

Parameters:
- WAIT_CYCLES, 4: data-memory access latency in cycles, legal 1..15.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- idSrc1  in  4  Rn index of the instruction in ID
- idSrc2  in  4  second source index of the instruction in ID
- idTwoSrc  in  1  ID instruction reads idSrc2
- idUsesSrc1  in  1  ID instruction reads idSrc1
- exeWbEn  in  1  EXE-stage instruction writes back
- exeMemRead  in  1  EXE-stage instruction is a load
- exeDest  in  4  EXE-stage destination
- memWbEn  in  1  MEM-stage instruction writes back
- memDest  in  4  MEM-stage destination
- memReq  in  1  MEM-stage instruction performs a load or store
- branchTaken  in  1  EXE-stage branch taken
- pipeReady  out  1  ready to all stage registers; 0 freezes the whole pipe
- pcFreeze  out  1  hold PC
- ifIdFreeze  out  1  hold IF/ID register
- ifIdFlush  out  1  clear IF/ID register
- idExFlush  out  1  load a bubble into the ID/EXE register
- memBusy  out  1  memory access in progress
- memDone  out  1  one-cycle pulse: access completes this cycle
- stallCount  out  CNT_W  saturating count of hazard-stall cycles
- flushCount  out  CNT_W  saturating count of branch flushes

Behaviour:
- FSM states: IDLE, WAIT, DONE. Counter `cnt` is 4 bits.
- IDLE:
  - memReq=1: pipeReady=0, memBusy=1, load cnt=WAIT_CYCLES-1, go to WAIT.
  - Otherwise pipeReady=1.
- WAIT:
  - pipeReady=0, memBusy=1.
  - cnt!=0: decrement.
  - cnt==0: go to DONE.
- DONE:
  - pipeReady=1, memDone=1, memBusy=0.
  - memReq is ignored; it is the request just served.
  - Always go to IDLE.
- Freeze length: a request seen in cycle t holds pipeReady low for WAIT_CYCLES+1 cycles. DONE is cycle t+WAIT_CYCLES+1.
- Hazard detection (combinational):
  - hz1 = idUsesSrc1 & match(idSrc1)
  - hz2 = idTwoSrc & match(idSrc2)
  - hazard = hz1 | hz2
- Branch: when branchTaken=1 and pipeReady=1:
  - assert ifIdFlush=1 and idExFlush=1;
  - suppress hazard outputs;
  - flushCount increments.
- Hazard outputs: when hazard=1, branchTaken=0 and pipeReady=1:
  - pcFreeze=1, ifIdFreeze=1, idExFlush=1;
  - stallCount increments.
- While pipeReady=0:
  - pcFreeze, ifIdFreeze, ifIdFlush and idExFlush are all 0; the global freeze covers them.
  - Counters hold.
- Counters saturate at all-ones and never wrap.
- Reset, including mid-WAIT:
  - next cycle is IDLE, cnt=0, both counters 0;
  - pipeReady=1; all other 1-bit outputs 0 (absent an active memReq or hazard).
- Register index 15 (PC) never produces a hazard match.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- Defined: forwarding exists.
  - match(x) = exeMemRead & exeWbEn & (exeDest==x).
  - Only load-use stalls; memWbEn and memDest are ignored.
- Undefined: no forwarding.
  - match(x) = (exeWbEn & exeDest==x) | (memWbEn & memDest==x).

Test Plan:
- Memory freeze: WAIT_CYCLES=4, memReq=1 held from cycle 10 → pipeReady=0 in cycles 10-14; pipeReady=1 and memDone=1 in cycle 15; IDLE in cycle 16.
- RAW stall without the macro: idSrc1=3, idUsesSrc1=1, memWbEn=1, memDest=3 → pcFreeze=ifIdFreeze=idExFlush=1; stallCount 0→1.
- Load-use with HAZARD_FORWARD_EN: exeMemRead=1, exeWbEn=1, exeDest=5, idSrc2=5, idTwoSrc=1 → stall. Same inputs with exeMemRead=0 → no stall.
- Branch priority: branchTaken=1 together with a RAW hazard → ifIdFlush=idExFlush=1, pcFreeze=0; flushCount=1, stallCount unchanged.
- Branch during freeze: branchTaken=1 in WAIT → all flushes 0. In DONE → flush asserted.
- Reset mid-access: rst=1 during WAIT (cnt=2) → next cycle pipeReady=1, memBusy=0; counters 0. Also preload stallCount=0xFFFF and hold a hazard → stays 0xFFFF.
